hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Execute-stage consumer of the decoded 5-bit ALU control code, for the multiply/divide subset: SIG_ALU_MULT, SIG_ALU_MULTU, SIG_ALU_DIV and SIG_ALU_DIVU.
- Owns the architectural HI/LO register pair and serves MFHI/MFLO reads.
- Multiplies complete in one cycle. Divides run on an iterative radix-2 restoring divider and stall the pipeline.
- Also accepts MTHI/MTLO-style writes from writeback and an exception flush.

Parameters:
- DATA_W, 32, operand width; HI and LO are each DATA_W.
- DIV_CYCLES, 32, divide iterations; must equal DATA_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  an instruction is present in E this cycle.
- alucontrol_i  in  5  SIG_ALU_* code from the decoder.
- srca_i  in  DATA_W  rs operand.
- srcb_i  in  DATA_W  rt operand.
- flush_i  in  1  exception flush; cancels an in-flight divide.
- hilo_we_i  in  2  bit1 writes HI, bit0 writes LO (MTHI/MTLO from W).
- hilo_wdata_i  in  DATA_W  write data for hilo_we_i.
- stall_o  out  1  hold F/D/E; divider busy.
- hi_o  out  DATA_W  current HI.
- lo_o  out  DATA_W  current LO.

Behaviour:
- Reset (rst=1 at an edge): HI=0, LO=0, state=IDLE, counter=0, stall_o=0. Reset mid-divide aborts it with no HI/LO write.
- States: IDLE, BUSY.
- Issue is valid_i && !flush_i && state==IDLE.
- MULT/MULTU:
  - {HI,LO} <= 64-bit product at the end of the issue cycle. Signed for MULT, unsigned for MULTU.
  - No stall. Result is readable via hi_o/lo_o the next cycle.
- DIV/DIVU:
  - Issue in cycle 0. stall_o is asserted combinationally in cycle 0.
  - Cycle 0: latch |srca|, |srcb| (raw values for DIVU), the quotient sign (sa^sb) and the remainder sign (sa). Move to BUSY with counter=0.
  - Cycles 1..32: one quotient bit per cycle; counter increments.
  - In the cycle with counter==31: the final bit is resolved and the sign fix is applied combinationally. LO<=quotient and HI<=remainder at that cycle's end. Return to IDLE.
  - stall_o is high cycles 0..32 and low in cycle 33.
  - Semantics are truncating: quotient rounds toward zero; remainder takes the dividend's sign.
- Divide by zero (srcb==0): runs the full length, no exception.
  - DIVU: LO=0xFFFFFFFF, HI=srca.
  - DIV: LO = 0xFFFFFFFF if srca>=0, else 0x00000001; HI=srca.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- flush_i:
  - In BUSY: return to IDLE next cycle, HI/LO unchanged.
  - In the issue cycle: no issue.
  - stall_o drops in the cycle flush_i is seen.
- Any other alucontrol code: no effect on this block.
- hilo_we_i writes take effect at the edge with no stall dependency.
- Same-edge collision: a divide completion or multiply writes HI/LO in preference to hilo_we_i, since the W-stage instruction is older.
- Same-edge collision between a HI-only and a LO-only write: both occur.
- hi_o/lo_o are direct register outputs, with no bypass of a same-cycle write. E-stage MFHI/MFLO forwarding from W is the datapath's job.

Decomposition:
- SIG_ALU_* codes stay in the existing shared ALU-control header; no new codes.
- State encoding (IDLE/BUSY) is a localparam.
- One sub-module, div_radix2: start/flush/signed inputs, busy/done outputs, quotient/remainder outputs.
- The multiplier and HI/LO arbitration live in the top.

Test Plan:
- MULT 0xFFFFFFFE × 0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA next cycle, stall_o never high. Same operands with MULTU → HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 → stall_o high for exactly 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5 after 33 cycles. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV issued, flush_i at cycle 10 → stall_o low that cycle; HI/LO keep their pre-issue values; a new MULT 2×3 two cycles later gives LO=6.
- hilo_we_i=2'b10 with data 0x1234 at the same edge as divide completion → HI holds the divide remainder. hilo_we_i=2'b01 while idle → LO=0x1234 next cycle.
- rst asserted at divide cycle 15 → HI=LO=0, stall_o=0 next cycle; no late write ever occurs.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg
//   Shared definitions for the HI/LO multiply/divide unit: the SIG_ALU_*
//   control codes it consumes, the divider FSM state encoding, and a small
//   helper that takes the magnitude of an optionally-signed operand.
//   No ports (package).
package hilo_muldiv_pkg;

    // ALU control codes for the multiply/divide subset, as produced by the
    // decoder. Other codes are not acted on by this block.
    localparam logic [4:0] SIG_ALU_MULT  = 5'b10000;
    localparam logic [4:0] SIG_ALU_MULTU = 5'b10001;
    localparam logic [4:0] SIG_ALU_DIV   = 5'b10010;
    localparam logic [4:0] SIG_ALU_DIVU  = 5'b10011;

    // Divider FSM state encoding.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY
    } div_state_t;

    // Magnitude of a DATA_W-bit operand; raw value when unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        abs32 = (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// div_radix2
//   Iterative radix-2 restoring divider, one quotient bit per cycle.
//   Operand magnitudes and result signs are captured on start; the last
//   quotient bit and the sign fix are resolved combinationally in the final
//   busy cycle, which is when done pulses with valid quotient/remainder.
//   Results are truncating: quotient toward zero, remainder takes the
//   dividend's sign. Divide by zero completes normally (quotient all ones
//   in magnitude, remainder = dividend).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a divide (ignored unless idle)
//   flush         abandon an in-flight divide; no done is produced
//   is_signed     1 = DIV semantics, 0 = DIVU
//   dividend      srca
//   divisor       srcb
//   busy          FSM is in BUSY
//   done          final cycle; quotient/remainder valid this cycle
//   quotient      signed-corrected quotient (valid with done)
//   remainder     signed-corrected remainder (valid with done)
module div_radix2
    import hilo_muldiv_pkg::*;
#(
    parameter int W     = 32,
    parameter int ITERS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic         is_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     quo_q;   // dividend bits shift out the top, quotient bits in at the bottom
    logic [W-1:0]     rem_q;
    logic [W-1:0]     dsr_q;
    logic             q_neg;
    logic             r_neg;

    logic [W:0]   rem_shift;
    logic [W:0]   diff;
    logic         bit_ok;
    logic [W-1:0] rem_next;
    logic [W-1:0] quo_next;
    logic         last;
    logic [W-1:0] a_abs;
    logic [W-1:0] b_abs;

    always_comb begin
        a_abs = (is_signed && dividend[W-1]) ? (~dividend + 1'b1) : dividend;
        b_abs = (is_signed && divisor[W-1])  ? (~divisor + 1'b1)  : divisor;
    end

    // One restoring step: the partial remainder is always below the divisor,
    // so the shifted value fits W+1 bits and diff[W] is the borrow.
    always_comb begin
        rem_shift = {rem_q, quo_q[W-1]};
        diff      = rem_shift - {1'b0, dsr_q};
        bit_ok    = ~diff[W];
        rem_next  = bit_ok ? diff[W-1:0] : rem_shift[W-1:0];
        quo_next  = {quo_q[W-2:0], bit_ok};
    end

    always_comb begin
        busy      = (state == BUSY);
        last      = busy && (count == LAST);
        done      = last && !flush;
        quotient  = q_neg ? (~quo_next + 1'b1) : quo_next;
        remainder = r_neg ? (~rem_next + 1'b1) : rem_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo_q <= a_abs;
                        rem_q <= '0;
                        dsr_q <= b_abs;
                        q_neg <= is_signed && (dividend[W-1] ^ divisor[W-1]);
                        r_neg <= is_signed && dividend[W-1];
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (last) begin
                        quo_q <= quo_next;
                        rem_q <= rem_next;
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        quo_q <= quo_next;
                        rem_q <= rem_next;
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
//   Execute-stage multiply/divide unit owning the architectural HI/LO pair.
//   MULT/MULTU write the 64-bit product at the end of the issue cycle.
//   DIV/DIVU run on div_radix2 for DIV_CYCLES+1 stalled cycles.
//   Writeback MTHI/MTLO writes arrive on hilo_we_i/hilo_wdata_i.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_i         instruction present in E this cycle
//   alucontrol_i    SIG_ALU_* code
//   srca_i, srcb_i  rs / rt operands
//   flush_i         exception flush; cancels issue and in-flight divide
//   hilo_we_i       bit1 writes HI, bit0 writes LO
//   hilo_wdata_i    data for hilo_we_i
//   stall_o         hold F/D/E while the divider owns the unit
//   hi_o, lo_o      current HI / LO registers (no same-cycle bypass)
//
// Handshake: an instruction is accepted when valid_i is high, flush_i is low
// and the divider is idle. stall_o acts as not-ready for the upstream stages:
// it is high from the divide issue cycle through the final divide cycle, and
// is forced low in any cycle where flush_i is high.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [4:0]        alucontrol_i,
    input  logic [DATA_W-1:0] srca_i,
    input  logic [DATA_W-1:0] srcb_i,
    input  logic              flush_i,
    input  logic [1:0]        hilo_we_i,
    input  logic [DATA_W-1:0] hilo_wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic                is_mult;
    logic                is_multu;
    logic                is_div;
    logic                is_divu;
    logic                issue;
    logic                mul_issue;
    logic                div_issue;
    logic                div_busy;
    logic                div_done;
    logic [DATA_W-1:0]   div_quo;
    logic [DATA_W-1:0]   div_rem;
    logic [2*DATA_W-1:0] mul_a;
    logic [2*DATA_W-1:0] mul_b;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    always_comb begin
        is_mult   = (alucontrol_i == SIG_ALU_MULT);
        is_multu  = (alucontrol_i == SIG_ALU_MULTU);
        is_div    = (alucontrol_i == SIG_ALU_DIV);
        is_divu   = (alucontrol_i == SIG_ALU_DIVU);
        issue     = valid_i && !flush_i && !div_busy;
        mul_issue = issue && (is_mult || is_multu);
        div_issue = issue && (is_div || is_divu);
        stall_o   = !flush_i && (div_busy || div_issue);
    end

    // Extend both operands to 2*DATA_W (sign- or zero-) so one unsigned
    // multiply truncated to 2*DATA_W gives the correct product either way.
    always_comb begin
        mul_a   = is_mult ? {{DATA_W{srca_i[DATA_W-1]}}, srca_i} : {{DATA_W{1'b0}}, srca_i};
        mul_b   = is_mult ? {{DATA_W{srcb_i[DATA_W-1]}}, srcb_i} : {{DATA_W{1'b0}}, srcb_i};
        product = mul_a * mul_b;
    end

    div_radix2 #(
        .W     (DATA_W),
        .ITERS (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_issue),
        .flush     (flush_i),
        .is_signed (is_div),
        .dividend  (srca_i),
        .divisor   (srcb_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // E-stage results beat W-stage MTHI/MTLO: the W instruction is older, so
    // the E result must be the one left in HI/LO. A divide completion and a
    // multiply issue can never coincide (multiply needs the divider idle).
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (div_done) begin
            hi_q <= div_rem;
            lo_q <= div_quo;
        end else if (mul_issue) begin
            hi_q <= product[2*DATA_W-1:DATA_W];
            lo_q <= product[DATA_W-1:0];
        end else begin
            if (hilo_we_i[1]) hi_q <= hilo_wdata_i;
            if (hilo_we_i[0]) lo_q <= hilo_wdata_i;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int W = 32;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [4:0]   alucontrol_i;
  logic [W-1:0] srca_i;
  logic [W-1:0] srcb_i;
  logic         flush_i;
  logic [1:0]   hilo_we_i;
  logic [W-1:0] hilo_wdata_i;
  logic         stall_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .alucontrol_i (alucontrol_i),
    .srca_i       (srca_i),
    .srcb_i       (srcb_i),
    .flush_i      (flush_i),
    .hilo_we_i    (hilo_we_i),
    .hilo_wdata_i (hilo_wdata_i),
    .stall_o      (stall_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [W-1:0] hi_v, input logic [W-1:0] lo_v);
    hilo_we_i = 2'b10; hilo_wdata_i = hi_v;
    tick;
    hilo_we_i = 2'b01; hilo_wdata_i = lo_v;
    tick;
    hilo_we_i = 2'b00; hilo_wdata_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    tests_run++;
    if (hi_o !== 32'h0) begin
      tests_failed++; $display("FAIL reset_hi: got %h expected %h", hi_o, 32'h0);
    end
    tests_run++;
    if (lo_o !== 32'h0) begin
      tests_failed++; $display("FAIL reset_lo: got %h expected %h", lo_o, 32'h0);
    end
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall_o);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_mult(input logic [4:0] alu, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string name);
    valid_i = 1'b1; alucontrol_i = alu; srca_i = a; srcb_i = b;
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL %s_stall_issue: got %b expected 0", name, stall_o);
    end
    tick;
    valid_i = 1'b0;
    #1;
    tests_run++;
    if (hi_o !== exp_hi) begin
      tests_failed++; $display("FAIL %s_hi: got %h expected %h", name, hi_o, exp_hi);
    end
    tests_run++;
    if (lo_o !== exp_lo) begin
      tests_failed++; $display("FAIL %s_lo: got %h expected %h", name, lo_o, exp_lo);
    end
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL %s_stall_after: got %b expected 0", name, stall_o);
    end
  endtask

  // Issues a divide and counts stall cycles. With collide set, an MTHI of
  // 0x1234 is presented in the last stalled cycle.
  task automatic test_div(input logic [4:0] alu, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic collide, input string name);
    int n;
    valid_i = 1'b1; alucontrol_i = alu; srca_i = a; srcb_i = b;
    #1;
    n = 0;
    while (stall_o === 1'b1 && n < 100) begin
      if (collide && n == 32) begin
        hilo_we_i = 2'b10; hilo_wdata_i = 32'h0000_1234;
      end
      n++;
      tick;
      valid_i = 1'b0; hilo_we_i = 2'b00; hilo_wdata_i = '0;
      srca_i = $urandom; srcb_i = $urandom;
      #1;
    end
    tests_run++;
    if (n != 33) begin
      tests_failed++; $display("FAIL %s_stall_cycles: got %0d expected 33", name, n);
    end
    tests_run++;
    if (hi_o !== exp_hi) begin
      tests_failed++; $display("FAIL %s_hi: got %h expected %h", name, hi_o, exp_hi);
    end
    tests_run++;
    if (lo_o !== exp_lo) begin
      tests_failed++; $display("FAIL %s_lo: got %h expected %h", name, lo_o, exp_lo);
    end
  endtask

  task automatic test_hilo_write;
    preload(32'hCAFE_0000, 32'h0000_0000);
    hilo_we_i = 2'b01; hilo_wdata_i = 32'h0000_1234;
    tick;
    hilo_we_i = 2'b00; hilo_wdata_i = '0;
    tests_run++;
    if (lo_o !== 32'h0000_1234) begin
      tests_failed++; $display("FAIL mtlo_lo: got %h expected %h", lo_o, 32'h0000_1234);
    end
    tests_run++;
    if (hi_o !== 32'hCAFE_0000) begin
      tests_failed++; $display("FAIL mtlo_hi_kept: got %h expected %h", hi_o, 32'hCAFE_0000);
    end
    // HI-only and LO-only writes on the same edge both land
    hilo_we_i = 2'b11; hilo_wdata_i = 32'h0BAD_F00D;
    tick;
    hilo_we_i = 2'b00;
    tests_run++;
    if (hi_o !== 32'h0BAD_F00D || lo_o !== 32'h0BAD_F00D) begin
      tests_failed++; $display("FAIL mthilo_both: got hi=%h lo=%h expected %h", hi_o, lo_o, 32'h0BAD_F00D);
    end
  endtask

  task automatic test_other_code;
    preload(32'h1111_1111, 32'h2222_2222);
    valid_i = 1'b1; alucontrol_i = 5'b00000; srca_i = 32'd9; srcb_i = 32'd3;
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL other_stall: got %b expected 0", stall_o);
    end
    tick;
    valid_i = 1'b0;
    tests_run++;
    if (hi_o !== 32'h1111_1111 || lo_o !== 32'h2222_2222) begin
      tests_failed++; $display("FAIL other_hilo: got hi=%h lo=%h expected 11111111/22222222", hi_o, lo_o);
    end
  endtask

  task automatic test_flush;
    preload(32'hAAAA_0000, 32'h0000_5555);
    // flush in the issue cycle: nothing starts
    valid_i = 1'b1; alucontrol_i = SIG_ALU_DIVU; srca_i = 32'd100; srcb_i = 32'd7; flush_i = 1'b1;
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush_issue_stall: got %b expected 0", stall_o);
    end
    tick;
    valid_i = 1'b0; flush_i = 1'b0;
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush_issue_noissue: got stall %b expected 0", stall_o);
    end
    // flush in cycle 10 of a running divide
    valid_i = 1'b1; alucontrol_i = SIG_ALU_DIV; srca_i = 32'hFFFF_FFF9; srcb_i = 32'd2;
    tick;
    valid_i = 1'b0;
    for (int i = 1; i < 10; i++) tick;
    flush_i = 1'b1;
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush_busy_stall: got %b expected 0", stall_o);
    end
    tick;
    flush_i = 1'b0;
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush_after_stall: got %b expected 0", stall_o);
    end
    tests_run++;
    if (hi_o !== 32'hAAAA_0000 || lo_o !== 32'h0000_5555) begin
      tests_failed++; $display("FAIL flush_hilo_kept: got hi=%h lo=%h expected aaaa0000/00005555", hi_o, lo_o);
    end
    tick;
    test_mult(SIG_ALU_MULT, 32'd2, 32'd3, 32'h0, 32'd6, "flush_then_mult");
    // nothing late shows up where the cancelled divide would have finished
    for (int i = 0; i < 30; i++) tick;
    tests_run++;
    if (hi_o !== 32'h0 || lo_o !== 32'd6) begin
      tests_failed++; $display("FAIL flush_no_late_write: got hi=%h lo=%h expected 0/6", hi_o, lo_o);
    end
  endtask

  task automatic test_reset_mid_div;
    logic late;
    preload(32'h0000_0011, 32'h0000_0022);
    valid_i = 1'b1; alucontrol_i = SIG_ALU_DIV; srca_i = 32'hFFFF_FFF9; srcb_i = 32'd2;
    tick;
    valid_i = 1'b0;
    for (int i = 1; i < 15; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    tests_run++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      tests_failed++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h expected 0/0", hi_o, lo_o);
    end
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_stall: got %b expected 0", stall_o);
    end
    late = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (hi_o !== 32'h0 || lo_o !== 32'h0 || stall_o !== 1'b0) late = 1'b1;
    end
    tests_run++;
    if (late !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_late_write: got late=%b expected 0", late);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; alucontrol_i = '0; srca_i = '0; srcb_i = '0;
    flush_i = 1'b0; hilo_we_i = 2'b00; hilo_wdata_i = '0;
    test_reset;
    test_mult(SIG_ALU_MULT,  32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
    test_mult(SIG_ALU_MULTU, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    test_div(SIG_ALU_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7_2");
    test_div(SIG_ALU_DIVU, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, "divu_100_7");
    test_div(SIG_ALU_DIVU, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b0, "divu_by0");
    test_div(SIG_ALU_DIV,  32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'h0000_0001, 1'b0, "div_neg_by0");
    test_div(SIG_ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0, "div_ovf");
    test_div(SIG_ALU_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, "div_7_neg2");
    test_div(SIG_ALU_DIVU, 32'd100,       32'd7,        32'd2,         32'd14,        1'b1, "div_collide");
    test_hilo_write;
    test_other_code;
    test_flush;
    test_reset_mid_div;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
